// File: rtl/disp_pkg.sv
// disp_pkg: glyph codes, display-state codes and constants for the reaction-timer display.
// Shared by core_fsm, disp_scan_ctrl and seg7_decode.
package disp_pkg;

  typedef enum logic [3:0] {
    G_0, G_1, G_2, G_3, G_4, G_5, G_6, G_7, G_8, G_9,
    G_BLANK, G_DASH, G_E, G_R
  } glyph_t;

  typedef enum logic {
    PAGE_LAST,
    PAGE_BEST
  } page_t;

  localparam logic [2:0] DST_IDLE    = 3'b000;
  localparam logic [2:0] DST_WAIT    = 3'b001;
  localparam logic [2:0] DST_MEASURE = 3'b010;
  localparam logic [2:0] DST_EARLY   = 3'b011;
  localparam logic [2:0] DST_FINISH  = 3'b110;

  localparam logic [23:0] NO_RESULT   = 24'hFFFFFF;
  localparam int          DEAD_CYCLES = 16;

  // Non-decimal nibbles are shown as a dash rather than a bogus digit.
  function automatic glyph_t nibble_glyph(input logic [3:0] n);
    return (n > 4'd9) ? G_DASH : glyph_t'(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational glyph to segment map, output ordered {g,f,e,d,c,b,a}, active-high.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] i_glyph,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_glyph)
      G_0:     o_seg = 7'h3F;
      G_1:     o_seg = 7'h06;
      G_2:     o_seg = 7'h5B;
      G_3:     o_seg = 7'h4F;
      G_4:     o_seg = 7'h66;
      G_5:     o_seg = 7'h6D;
      G_6:     o_seg = 7'h7D;
      G_7:     o_seg = 7'h07;
      G_8:     o_seg = 7'h7F;
      G_9:     o_seg = 7'h6F;
      G_DASH:  o_seg = 7'h40;
      G_E:     o_seg = 7'h79;
      G_R:     o_seg = 7'h50;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scans a 6-digit 7-segment display, rendering the core's results and status.
// Define DISP_DEADTIME_EN to blank the last DEAD_CYCLES cycles of every digit slot.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV   = 4000,
  parameter int PAGE_SCANS = 2000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_dst,
  input  logic [23:0] i_last,
  input  logic [23:0] i_best,
  output logic [5:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int SCAN_W = $clog2(PAGE_SCANS + 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [2:0]        dig_q, dig_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  page_t             page_q, page_d;
  logic              blink_q, blink_d;
  logic [23:0]       last_q, last_d;
  logic [23:0]       best_q, best_d;
  logic [2:0]        dst_q, dst_d;
  logic [5:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              slot_end;
  logic              scan_start;
  logic              mode_chg;
  logic              period_done;
  logic [23:0]       value;
  logic [3:0]        nib;
  glyph_t            glyph;
  logic              dp_raw;
  logic [6:0]        seg_raw;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_q  <= '0;
      dig_q   <= 3'd0;
      scan_q  <= '0;
      blink_q <= 1'b0;
      last_q  <= NO_RESULT;
      best_q  <= NO_RESULT;
      dst_q   <= DST_IDLE;
      an_q    <= 6'd0;
      seg_q   <= 7'd0;
      dp_q    <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      dig_q   <= dig_d;
      scan_q  <= scan_d;
      blink_q <= blink_d;
      last_q  <= last_d;
      best_q  <= best_d;
      dst_q   <= dst_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  // The scan-start edge renders digit 0 straight from the inputs it is latching.
  always_comb begin
    slot_end    = (slot_q == SLOT_W'(SCAN_DIV - 1));
    scan_start  = (dig_q == 3'd0) && (slot_q == '0);
    slot_d      = slot_end ? '0 : slot_q + SLOT_W'(1);
    dig_d       = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
    end
    last_d      = scan_start ? i_last : last_q;
    best_d      = scan_start ? i_best : best_q;
    dst_d       = scan_start ? i_dst  : dst_q;
    mode_chg    = scan_start && (i_dst != dst_q);
    period_done = scan_start && (scan_q == SCAN_W'(PAGE_SCANS));
    scan_d      = scan_q;
    if (mode_chg || period_done) begin
      scan_d = '0;
    end else if (slot_end && (dig_q == 3'd5)) begin
      scan_d = scan_q + SCAN_W'(1);
    end
    blink_d = blink_q;
    if (mode_chg) begin
      blink_d = 1'b0;
    end else if (period_done && (dst_d == DST_EARLY)) begin
      blink_d = !blink_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      page_q <= PAGE_LAST;
    end else begin
      page_q <= page_d;
    end
  end

  // A mode change wins over a page flip landing on the same scan start.
  always_comb begin
    page_d = page_q;
    if (mode_chg) begin
      page_d = PAGE_LAST;
    end else if (period_done && (dst_d == DST_IDLE)) begin
      page_d = (page_q == PAGE_LAST) ? PAGE_BEST : PAGE_LAST;
    end
  end

  always_comb begin
    value = ((dst_d == DST_IDLE) && (page_d == PAGE_BEST)) ? best_d : last_d;
    case (dig_q)
      3'd0:    nib = value[3:0];
      3'd1:    nib = value[7:4];
      3'd2:    nib = value[11:8];
      3'd3:    nib = value[15:12];
      3'd4:    nib = value[19:16];
      default: nib = value[23:20];
    endcase
    glyph  = G_BLANK;
    dp_raw = 1'b0;
    case (dst_d)
      DST_IDLE, DST_FINISH: begin
        if (value == NO_RESULT) begin
          glyph = G_DASH;
        end else begin
          glyph  = nibble_glyph(nib);
          dp_raw = (dig_q == 3'd3);
          // Leading zeros above the ms digit are suppressed from the left.
          if ((dig_q == 3'd5) && (nib == 4'd0)) begin
            glyph = G_BLANK;
          end
          if ((dig_q == 3'd4) && (nib == 4'd0) && (value[23:20] == 4'd0)) begin
            glyph = G_BLANK;
          end
        end
      end
      DST_WAIT: glyph = G_DASH;
      DST_EARLY: begin
        if (!blink_d) begin
          case (dig_q)
            3'd5:       glyph = G_E;
            3'd4, 3'd3: glyph = G_R;
            default:    glyph = G_BLANK;
          endcase
        end
      end
      default: glyph = G_BLANK;
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_glyph (glyph),
    .o_seg   (seg_raw)
  );

  always_comb begin
    an_d  = 6'd1 << dig_q;
    seg_d = seg_raw;
    dp_d  = dp_raw;
`ifdef DISP_DEADTIME_EN
    if (slot_q >= SLOT_W'(SCAN_DIV - DEAD_CYCLES)) begin
      an_d  = 6'd0;
      seg_d = 7'd0;
      dp_d  = 1'b0;
    end
`endif
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl with a frame-level reference model.
// Honours DISP_DEADTIME_EN when the design is built with it.
module tb_disp_scan_ctrl;

  localparam int SD   = 32;
  localparam int PS   = 4;
  localparam int SCAN = 6 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dst;
  logic [23:0] last;
  logic [23:0] best;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;

  disp_scan_ctrl #(
    .SCAN_DIV   (SD),
    .PAGE_SCANS (PS)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_dst  (dst),
    .i_last (last),
    .i_best (best),
    .o_an   (an),
    .o_seg  (seg),
    .o_dp   (dp)
  );

  always #5 clk = ~clk;

  // Glyph numbering for the model: 0-9 digits, 10 blank, 11 dash, 12 E, 13 r.
  function automatic logic [6:0] segOf(input int g);
    case (g)
      0:       return 7'h3F;
      1:       return 7'h06;
      2:       return 7'h5B;
      3:       return 7'h4F;
      4:       return 7'h66;
      5:       return 7'h6D;
      6:       return 7'h7D;
      7:       return 7'h07;
      8:       return 7'h7F;
      9:       return 7'h6F;
      11:      return 7'h40;
      12:      return 7'h79;
      13:      return 7'h50;
      default: return 7'h00;
    endcase
  endfunction

  function automatic void valueGlyph(input logic [23:0] v, input int d, output int g, output logic p);
    logic [3:0] n;
    bit shown;
    if (v == 24'hFFFFFF) begin
      g = 11;
      p = 1'b0;
    end else begin
      n     = 4'(v >> (4 * d));
      shown = (d <= 3) || (d == 4 && v[23:16] != 8'h00) || (d == 5 && v[23:20] != 4'h0);
      g     = !shown ? 10 : (n > 4'd9) ? 11 : int'(n);
      p     = (d == 3);
    end
  endfunction

  // phase counts whole PAGE_SCANS periods since the mode was entered.
  function automatic void modelDigit(input logic [2:0] mode, input logic [23:0] lv, input logic [23:0] bv,
                                     input int phase, input int d, output logic [6:0] s, output logic p);
    int g;
    g = 10;
    p = 1'b0;
    case (mode)
      3'b000: valueGlyph((phase % 2 == 1) ? bv : lv, d, g, p);
      3'b110: valueGlyph(lv, d, g, p);
      3'b001: g = 11;
      3'b011: if (phase % 2 == 0) g = (d == 5) ? 12 : (d == 4 || d == 3) ? 13 : 10;
      default: g = 10;
    endcase
    s = segOf(g);
  endfunction

  int          cyc = 0;
  int          modeStartScan = 0;
  logic [2:0]  mDst = 3'b000;
  logic [23:0] mLast = 24'hFFFFFF;
  logic [23:0] mBest = 24'hFFFFFF;
  bit          expValid = 1'b0;
  int          lastPos = 0;
  int          lastScan = 0;
  logic [5:0]  expAn = 6'd0;
  logic [6:0]  expSeg = 7'd0;
  logic        expDp = 1'b0;
  int          mPos, mScan, mDig;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc           = 0;
      modeStartScan = 0;
      mDst          = 3'b000;
      mLast         = 24'hFFFFFF;
      mBest         = 24'hFFFFFF;
      expValid      = 1'b0;
    end else begin
      mPos  = cyc % SCAN;
      mScan = cyc / SCAN;
      if (mPos == 0) begin
        if (dst != mDst) modeStartScan = mScan;
        mDst  = dst;
        mLast = last;
        mBest = best;
      end
      mDig = mPos / SD;
      modelDigit(mDst, mLast, mBest, (mScan - modeStartScan) / PS, mDig, expSeg, expDp);
      expAn = 6'd1 << mDig;
`ifdef DISP_DEADTIME_EN
      if ((mPos % SD) >= SD - 16) begin
        expAn  = 6'd0;
        expSeg = 7'd0;
        expDp  = 1'b0;
      end
`endif
      lastPos  = mPos;
      lastScan = mScan;
      expValid = 1'b1;
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [5:0] aAn, input logic [6:0] aSeg, input logic aDp,
                             input logic [5:0] eAn, input logic [6:0] eSeg, input logic eDp);
    checks++;
    if (aAn !== eAn || aSeg !== eSeg || aDp !== eDp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
               name, $time, aAn, aSeg, aDp, eAn, eSeg, eDp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) checkOutput("reset", an, seg, dp, 6'd0, 7'd0, 1'b0);
    else if (expValid) checkOutput("model", an, seg, dp, expAn, expSeg, expDp);
  end

  task automatic waitPos(input int scanNo, input int pos, input string name);
    int n;
    n = 0;
    while (!(expValid && lastScan == scanNo && lastPos == pos) && n < 50 * SCAN) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50 * SCAN) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: scan %0d pos %0d never reached, now scan %0d pos %0d",
               name, scanNo, pos, lastScan, lastPos);
    end
  endtask

  task automatic checkFrame(input int scanNo, input logic [41:0] segs, input logic [5:0] dpMask, input string name);
    for (int d = 0; d < 6; d++) begin
      waitPos(scanNo, d * SD + SD / 4, name);
      checkOutput($sformatf("%s_d%0d", name, d), an, seg, dp, 6'd1 << d, segs[d*7 +: 7], dpMask[d]);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] newDst, input logic [23:0] newLast, input logic [23:0] newBest);
    dst  = newDst;
    last = newLast;
    best = newBest;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(3'b000, 24'h000245, 24'h000198);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkFrame(0, {7'h00, 7'h00, 7'h3F, 7'h5B, 7'h66, 7'h6D}, 6'b001000, "idle_last");
    checkFrame(4, {7'h00, 7'h00, 7'h3F, 7'h06, 7'h6F, 7'h7F}, 6'b001000, "idle_best");

    waitPos(5, 2 * SD + 3, "set_noresult");
    applyStimulus(3'b000, 24'hFFFFFF, 24'h000198);
    checkFrame(8, {6{7'h40}}, 6'b000000, "no_result");

    waitPos(9, 10, "set_finish");
    applyStimulus(3'b110, 24'h012345, 24'h000198);
    checkFrame(10, {7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D}, 6'b001000, "finish_lead");
    waitPos(11, 10, "set_full");
    applyStimulus(3'b110, 24'h102345, 24'h000198);
    checkFrame(12, {7'h06, 7'h3F, 7'h5B, 7'h4F, 7'h66, 7'h6D}, 6'b001000, "finish_full");
    waitPos(13, 10, "set_hex");
    applyStimulus(3'b110, 24'h00C2F1, 24'h000198);

    waitPos(14, 10, "set_early");
    applyStimulus(3'b011, 24'h00C2F1, 24'h000198);
    checkFrame(15, {7'h79, 7'h50, 7'h50, 7'h00, 7'h00, 7'h00}, 6'b000000, "early_on");
    checkFrame(19, {6{7'h00}}, 6'b000000, "early_off");
    waitPos(24, 50, "set_idle");
    applyStimulus(3'b000, 24'h000245, 24'h000198);
    checkFrame(25, {7'h00, 7'h00, 7'h3F, 7'h5B, 7'h66, 7'h6D}, 6'b001000, "early_to_idle");

    waitPos(26, 2 * SD + 5, "set_tear");
    applyStimulus(3'b000, 24'h123777, 24'h000198);
    waitPos(26, 3 * SD + 10, "tear_d3");
    checkOutput("tear_d3", an, seg, dp, 6'b001000, 7'h3F, 1'b1);
    waitPos(26, 5 * SD + 10, "tear_d5");
    checkOutput("tear_d5", an, seg, dp, 6'b100000, 7'h00, 1'b0);
    checkFrame(27, {7'h06, 7'h5B, 7'h4F, 7'h07, 7'h07, 7'h07}, 6'b001000, "tear_next");

    waitPos(28, 10, "set_wait");
    applyStimulus(3'b001, 24'h123777, 24'h000198);
    checkFrame(29, {6{7'h40}}, 6'b000000, "wait_dash");
    waitPos(30, 10, "set_measure");
    applyStimulus(3'b010, 24'h123777, 24'h000198);
    waitPos(31, 10, "set_other");
    applyStimulus(3'b101, 24'h123777, 24'h000198);
    checkFrame(32, {6{7'h00}}, 6'b000000, "other_blank");
    waitPos(33, 10, "set_idle2");
    applyStimulus(3'b000, 24'h123777, 24'h000198);

    waitPos(34, SD + 7, "mid_slot");
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", an, seg, dp, 6'd0, 7'd0, 1'b0);
    repeat (2) @(negedge clk);
    applyStimulus(3'b000, 24'h000245, 24'h000198);
    rst = 1'b0;
    checkFrame(0, {7'h00, 7'h00, 7'h3F, 7'h5B, 7'h66, 7'h6D}, 6'b001000, "post_reset");
    waitPos(1, 20, "tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
